tile_frame_gen: RTL and testbench

- Upstream pixel source for the SSD1306 SPI serializer in the piano-tiles display path.
- Renders a 4-lane scrolling tile field into display bytes, in SSD1306 horizontal-addressing order: page 0..7, column 0..127 within each page, byte bit b = pixel row 8*page+b.
- Streams the bytes over a valid/ready handshake. The serializer pulls one byte per 8-bit SPI transfer.
- Latches the game state once per frame so the panel never shows a torn frame.

---
 rtl/tile_frame_gen_pkg.sv | 37 +++
 rtl/tile_frame_gen_if.sv | 11 +
 rtl/tile_frame_gen_pixel_col.sv | 32 +++
 rtl/tile_frame_gen.sv | 100 ++++++++++
 tb/tb_tile_frame_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/tile_frame_gen_pkg.sv
// Shared display constants for the piano-tiles SSD1306 path: geometry,
// panel command bytes and the tile-map row type.
package tile_frame_gen_pkg;

  localparam int COLS       = 128;
  localparam int PAGES      = 8;
  localparam int LANE_W     = 32;
  localparam int TILE_H     = 16;
  localparam int LANES      = COLS / LANE_W;
  localparam int ROWS       = PAGES * 8 / TILE_H + 1;
  localparam int MAP_W      = ROWS * LANES;

  localparam int COL_W      = $clog2(COLS);
  localparam int PAGE_W     = $clog2(PAGES);
  localparam int SCROLL_W   = $clog2(TILE_H);
  localparam int LANE_SH    = $clog2(LANE_W);
  localparam int LANE_IDX_W = $clog2(LANES);
  localparam int TILE_SH    = $clog2(TILE_H);
  localparam int ROW_IDX_W  = $clog2(ROWS);
  localparam int YY_W       = TILE_SH + ROW_IDX_W;

  localparam logic [7:0] SSD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] SSD_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] SSD_MEM_MODE    = 8'h20;
  localparam logic [7:0] SSD_COL_ADDR    = 8'h21;
  localparam logic [7:0] SSD_PAGE_ADDR   = 8'h22;
  localparam logic [7:0] SSD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] SSD_CONTRAST    = 8'h81;

  typedef logic [LANES-1:0] lane_mask_t;

  typedef enum logic {
    ST_SNAP,
    ST_RUN
  } gen_state_t;

endpackage

// File: rtl/tile_frame_gen_if.sv
// Byte stream from the frame generator to the SSD1306 serializer.
interface tile_frame_gen_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_sof;
  logic       frame_done;

  modport master (output byte_data, byte_valid, byte_sof, frame_done, input byte_ready);
  modport slave  (input byte_data, byte_valid, byte_sof, frame_done, output byte_ready);
endinterface

// File: rtl/tile_frame_gen_pixel_col.sv
// Combinational renderer: one display byte (8 vertical pixels) for a
// given column/page from the latched tile map, scroll and invert.
module tile_pixel_col
  import tile_frame_gen_pkg::*;
(
  input  logic [COL_W-1:0]          col,
  input  logic [PAGE_W-1:0]         page,
  input  lane_mask_t [ROWS-1:0]     map,
  input  logic [SCROLL_W-1:0]       scroll,
  input  logic                      invert,
  output logic [7:0]                data
);

  logic [LANE_IDX_W-1:0] lane;
  logic [LANE_SH-1:0]    x_in;
  logic                  edge_ok;

  assign lane    = col[COL_W-1:LANE_SH];
  assign x_in    = col[LANE_SH-1:0];
  // First and last column of each lane stay dark as a lane separator.
  assign edge_ok = (x_in != '0) && (x_in != '1);

  for (genvar b = 0; b < 8; b++) begin : g_bit
    logic [YY_W-1:0]      yy;
    logic [ROW_IDX_W-1:0] row;

    assign yy      = YY_W'({page, 3'(b)}) + YY_W'(TILE_H) - YY_W'(scroll);
    assign row     = yy[YY_W-1:TILE_SH];
    assign data[b] = (map[row][lane] & edge_ok & (yy[TILE_SH-1:0] != '0)) ^ invert;
  end

endmodule

// File: rtl/tile_frame_gen.sv
// Frame sequencer: latches game state per frame and streams display bytes
// in SSD1306 horizontal-addressing order over a valid/ready handshake.
//
// state   | meaning
// ST_SNAP | first cycle after reset: latch tile_map/scroll/invert
// ST_RUN  | stream bytes; re-latch inputs as the frame's last byte loads
module tile_frame_gen
  import tile_frame_gen_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [MAP_W-1:0]    tile_map,
  input  logic [SCROLL_W-1:0] scroll,
  input  logic                invert,
  tile_frame_gen_if.master    bus
);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

  gen_state_t              state;
  logic [COL_W-1:0]        col_q;
  logic [PAGE_W-1:0]       page_q;
  lane_mask_t [ROWS-1:0]   snap_map;
  logic [SCROLL_W-1:0]     snap_scroll;
  logic                    snap_inv;
  logic [7:0]              data_q;
  logic                    valid_q;
  logic                    sof_q;
  logic                    last_q;
  logic                    done_q;
  logic [7:0]              pix;
  logic                    load;
  logic                    at_end;

  assign load   = ~valid_q | bus.byte_ready;
  assign at_end = (col_q == COL_LAST) && (page_q == PAGE_LAST);

  tile_pixel_col u_pixel_col (
    .col    (col_q),
    .page   (page_q),
    .map    (snap_map),
    .scroll (snap_scroll),
    .invert (snap_inv),
    .data   (pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_SNAP;
      col_q       <= '0;
      page_q      <= '0;
      snap_map    <= '0;
      snap_scroll <= '0;
      snap_inv    <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= valid_q & bus.byte_ready & last_q;
      case (state)
        ST_SNAP: begin
          snap_map    <= tile_map;
          snap_scroll <= scroll;
          snap_inv    <= invert;
          state       <= ST_RUN;
        end
        ST_RUN: begin
          if (load) begin
            data_q  <= pix;
            valid_q <= 1'b1;
            sof_q   <= (col_q == '0) && (page_q == '0);
            last_q  <= at_end;
            if (col_q == COL_LAST) begin
              col_q  <= '0;
              page_q <= at_end ? '0 : page_q + PAGE_W'(1);
            end else begin
              col_q  <= col_q + COL_W'(1);
            end
            // Latch next frame's state so page 0/col 0 renders from it.
            if (at_end) begin
              snap_map    <= tile_map;
              snap_scroll <= scroll;
              snap_inv    <= invert;
            end
          end
        end
        default: state <= ST_SNAP;
      endcase
    end
  end

  assign bus.byte_data  = data_q;
  assign bus.byte_valid = valid_q;
  assign bus.byte_sof   = sof_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_tile_frame_gen.sv
// Directed/randomized bench for tile_frame_gen against an arithmetic pixel model.
module tb_tile_frame_gen;
  import tile_frame_gen_pkg::*;

  localparam int FRAME = COLS * PAGES;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] tile_map;
  logic [3:0]  scroll;
  logic        invert;

  tile_frame_gen_if bus();

  tile_frame_gen dut (
    .clk      (clk),
    .rst      (rst),
    .tile_map (tile_map),
    .scroll   (scroll),
    .invert   (invert),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_acc = 0;
  int          exp_idx = 0;
  bit          prev_stall = 1'b0;
  bit          done_pending = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_sof;
  logic [19:0] exp_map;
  int          exp_scroll;
  bit          exp_inv;
  logic [7:0]  cap [FRAME];

  function automatic logic [7:0] model_byte(logic [19:0] m, int s, bit inv, int x, int pg);
    logic [7:0] r;
    int y, yy, row, lane;
    bit lit;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      y    = 8 * pg + b;
      yy   = y + TILE_H - s;
      row  = yy / TILE_H;
      lane = x / LANE_W;
      lit  = m[row * 4 + lane] && (x % LANE_W != 0) && (x % LANE_W != LANE_W - 1)
             && (yy % TILE_H != 0);
      r[b] = lit ^ inv;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h (byte index %0d)", tag, obs, expv, exp_idx);
    end
  endtask

  // Evaluate the current sample point, drive ready, advance one cycle.
  task automatic step(input int pct);
    bit         rdy;
    logic [7:0] e;
    chk("frame_done", 32'(bus.frame_done), 32'(done_pending));
    done_pending = 1'b0;
    if (prev_stall) begin
      chk("hold_valid", 32'(bus.byte_valid), 32'(1));
      chk("hold_data", 32'(bus.byte_data), 32'(prev_data));
      chk("hold_sof", 32'(bus.byte_sof), 32'(prev_sof));
    end
    rdy = ($urandom_range(99) < 32'(pct));
    bus.byte_ready = rdy;
    if (bus.byte_valid === 1'b1 && rdy) begin
      if (exp_idx == 0) begin
        exp_map    = tile_map;
        exp_scroll = int'(scroll);
        exp_inv    = invert;
      end
      e = model_byte(exp_map, exp_scroll, exp_inv, exp_idx % COLS, exp_idx / COLS);
      chk("byte_data", 32'(bus.byte_data), 32'(e));
      chk("byte_sof", 32'(bus.byte_sof), 32'(exp_idx == 0));
      cap[exp_idx] = bus.byte_data;
      if (exp_idx == FRAME - 1) done_pending = 1'b1;
      exp_idx = (exp_idx + 1) % FRAME;
      n_acc++;
    end
    prev_stall = (bus.byte_valid === 1'b1) && !rdy;
    prev_data  = bus.byte_data;
    prev_sof   = bus.byte_sof;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int n, input int pct);
    int start, cyc;
    start = n_acc;
    cyc   = 0;
    while ((n_acc - start) < n && cyc < n * 25 + 50) begin
      step(pct);
      cyc++;
    end
    chk("accept_budget", 32'(n_acc - start), 32'(n));
  endtask

  task automatic reset_and_start();
    rst = 1'b1;
    bus.byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.byte_valid), 32'(0));
    chk("rst_data", 32'(bus.byte_data), 32'(0));
    chk("rst_sof", 32'(bus.byte_sof), 32'(0));
    chk("rst_done", 32'(bus.frame_done), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_c1_valid", 32'(bus.byte_valid), 32'(0));
    @(posedge clk);
    #1;
    chk("lat_c2_valid", 32'(bus.byte_valid), 32'(1));
    chk("lat_c2_sof", 32'(bus.byte_sof), 32'(1));
    exp_idx      = 0;
    prev_stall   = 1'b0;
    done_pending = 1'b0;
  endtask

  initial begin
    int bad;
    rst            = 1'b1;
    tile_map       = 20'h00010;
    scroll         = 4'd0;
    invert         = 1'b0;
    bus.byte_ready = 1'b1;

    // Frame 1: single tile, scroll 0; scroll 8 queued mid-frame.
    reset_and_start();
    run_until(500, 100);
    scroll = 4'd8;
    run_until(FRAME - 500, 100);
    chk("f1_p0c5", 32'(cap[5]), 32'h00FE);
    chk("f1_p1c5", 32'(cap[128 + 5]), 32'h00FF);
    chk("f1_p2c5", 32'(cap[256 + 5]), 32'h0000);
    chk("f1_p0c0", 32'(cap[0]), 32'h0000);
    chk("f1_p0c31", 32'(cap[31]), 32'h0000);
    chk("f1_p0c37", 32'(cap[37]), 32'h0000);

    // Frame 2: scroll 8 under backpressure; next frame map 1, scroll 15.
    run_until(500, 30);
    tile_map = 20'h00001;
    scroll   = 4'd15;
    run_until(FRAME - 500, 30);
    chk("f2_p0c5", 32'(cap[5]), 32'h0000);
    chk("f2_p1c5", 32'(cap[128 + 5]), 32'h00FE);
    chk("f2_p2c5", 32'(cap[256 + 5]), 32'h00FF);

    // Frame 3: scroll 15; queue empty map with invert.
    run_until(500, 100);
    tile_map = 20'h00000;
    invert   = 1'b1;
    run_until(FRAME - 500, 70);
    chk("f3_p0c5", 32'(cap[5]), 32'h00FF);
    chk("f3_p1c5", 32'(cap[128 + 5]), 32'h007F);

    // Frame 4: inverted empty field; queue random state.
    run_until(500, 50);
    tile_map = 20'($urandom);
    scroll   = 4'($urandom_range(15));
    invert   = 1'b0;
    run_until(FRAME - 500, 50);
    bad = 0;
    for (int i = 0; i < FRAME; i++) if (cap[i] !== 8'hFF) bad++;
    chk("f4_all_ff", 32'(bad), 32'(0));

    // Frame 5: random state, reset at page 3 col 40.
    run_until(3 * COLS + 40, 30);
    tile_map = 20'($urandom);
    scroll   = 4'($urandom_range(15));
    invert   = 1'($urandom_range(1));
    rst      = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(bus.byte_valid), 32'(0));
    chk("midrst_sof", 32'(bus.byte_sof), 32'(0));
    reset_and_start();
    run_until(FRAME, 30);
    step(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
